line_score_tracker: RTL
=======================

Name: line_score_tracker

Overview:
- Upstream feeder of the gravity-tick generator: turns line-clear and soft-drop events from the game FSM into the 4-bit `level` that sets fall speed.
- Keeps the running 6-digit BCD score for the HEX display.
- Keeps the cleared-line total.
- Scoring uses NES rules: base points per clear multiplied by (level+1), done as one BCD add per cycle.

Parameters:
- LINES_PER_LEVEL, 4'd10, lines cleared per level increment.
- MAX_LEVEL, 4'd15, level saturation value.
- MAX_LINES, 10'd999, line-counter saturation value.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- clear_valid  input  1  line-clear event request
- clear_count  input  3  lines cleared by this event (1..4 meaningful)
- clear_ready  output  1  tracker can accept a clear event (high only in IDLE)
- drop_point  input  1  single-cycle pulse: +1 point per soft-dropped row
- level  output  4  current level, drives the gravity-tick generator
- lines  output  10  binary cleared-line total
- score  output  24  6 BCD digits, [23:20] most significant
- level_up  output  1  one-cycle pulse when level increments
- busy  output  1  arithmetic in progress (= ~clear_ready)

Behaviour:
- Reset (async assert, sync release). Register values: level=0, lines=0, score=24'h000000, level_up=0, pending_drop=0, line_sub=0. State is IDLE, so clear_ready=1.
- Handshake: a clear is accepted on a rising edge where clear_valid&&clear_ready.
  - clear_valid may be held high; only one event is taken per accept.
  - After an accept, clear_ready drops until the next return to IDLE.
- Base points: 1->40, 2->100, 3->300, 4->1200 (BCD constants).
  - clear_count of 0 or 5..7 is accepted as a no-op: state stays IDLE and no registers change.
- FSM states: IDLE, ADD, UPDATE.
  - IDLE, on a valid accept: latch base, nclr=clear_count, reps=level+1 (captured; later level changes do not affect this event). Go to ADD.
  - ADD: score <= score +BCD base each cycle and reps decrements. Go to UPDATE after the last add, so ADD lasts level+1 cycles.
  - UPDATE (1 cycle): lines <= min(lines+nclr, MAX_LINES).
  - UPDATE, sub-counter: line_sub (0..LINES_PER_LEVEL-1) += nclr. On wrap (sum >= LINES_PER_LEVEL), line_sub <= sum-LINES_PER_LEVEL, and level increments if below MAX_LEVEL.
  - UPDATE, level_up pulse: level_up=1 on the cycle after UPDATE, only if level actually changed. At most one increment per event.
  - UPDATE exit: go to IDLE.
  - Latency: accept at edge T, then IDLE again (clear_ready=1) at edge T+level+2. New level and lines are visible from that edge.
- BCD add: per-digit add with +6 correction and carry ripple, all combinational within one cycle.
  - Overflow past 999999 follows SCORE_SAT_EN (see Optional Feature).
- drop_point:
  - In IDLE with no accept that cycle: score += 1 (BCD).
  - Otherwise: set pending_drop. A pending drop is applied on the first IDLE cycle with no accept.
  - Further pulses while pending_drop=1 are discarded. Soft-drop points never multiply by level.
- Reset mid-operation: the ADD/UPDATE sequence is aborted immediately and all registers return to reset values; a partial score is not kept.
- Outputs are registered; level has no combinational path from inputs.

Optional Feature:
- Macro SCORE_SAT_EN.
  - Defined: any BCD add whose result exceeds 999999 clamps score to 24'h999999, and further adds leave it there.
  - Undefined: the carry out of digit 5 is dropped and score wraps modulo 1,000,000 (e.g. 999990+40 -> 000030).
- Line and level saturation are unaffected by the macro.

Test Plan:
- Reset, then at level 0 a clear_count=1 accept -> clear_ready low for 2 cycles; score=000040, lines=1, level=0, no level_up.
- From reset, accept clear_count=4 three times -> score=003600, lines=12, level=1, level_up pulsed exactly once on the third event.
- Force level=2 (20 lines via ten clear_count=2 events), then accept clear_count=3 -> ADD lasts 3 cycles, score += 900, busy high for 4 cycles.
- drop_point in the same cycle as an accepted clear -> pending set, +1 applied on the first free IDLE cycle. A second drop_point during ADD is lost: net score +1 beyond clear points.
- Async rst asserted mid-ADD -> all outputs 0 immediately, clear_ready=1 after release. clear_count=0 and 6 are accepted with no change to score, lines or level.
- Preload score 999990, then clear_count=1 at level 0 -> 999999 with SCORE_SAT_EN defined, 000030 without. Lines saturate at 999, and level holds at 15 with no level_up.

Source files
------------

// File: rtl/line_score_tracker.sv
// Line/level/score tracker for the falling-block game: NES-style BCD scoring (one add per cycle),
// cleared-line total and level. Define SCORE_SAT_EN to clamp the score at 999999 instead of wrapping.
module line_score_tracker #(
    parameter logic [3:0] LINES_PER_LEVEL = 4'd10,
    parameter logic [3:0] MAX_LEVEL       = 4'd15,
    parameter logic [9:0] MAX_LINES       = 10'd999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_valid,
    input  logic [2:0]  clear_count,
    output logic        clear_ready,
    input  logic        drop_point,
    output logic [3:0]  level,
    output logic [9:0]  lines,
    output logic [23:0] score,
    output logic        level_up,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ADD    = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    logic [1:0]  state_reg;
    logic [15:0] base_reg;
    logic [2:0]  nclr_reg;
    logic [4:0]  reps_reg;
    logic        pending_drop_reg;
    logic [3:0]  line_sub_reg;
    logic [3:0]  level_reg;
    logic [9:0]  lines_reg;
    logic [23:0] score_reg;
    logic        level_up_reg;

    logic        count_ok;
    logic        take;
    logic [15:0] base_lut;
    logic [23:0] addend;
    logic [23:0] sum_digits;
    logic [6:0]  carry;
    logic [23:0] score_next;
    logic [9:0]  lines_sum;
    logic [9:0]  lines_next;
    logic [3:0]  sub_sum;

    assign count_ok = (clear_count != 3'd0) && (clear_count <= 3'd4);
    assign take     = clear_valid && (state_reg == IDLE) && count_ok;

    always_comb begin
        base_lut = 16'h0000;
        case (clear_count)
            3'd1:    base_lut = 16'h0040;
            3'd2:    base_lut = 16'h0100;
            3'd3:    base_lut = 16'h0300;
            3'd4:    base_lut = 16'h1200;
            default: base_lut = 16'h0000;
        endcase
    end

    // The single BCD adder serves both the multiplied clear points (ADD) and soft-drop +1 (IDLE).
    assign addend   = (state_reg == ADD) ? {8'h00, base_reg} : 24'h000001;
    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            logic [4:0] raw;
            logic [4:0] adj;
            assign raw = {1'b0, score_reg[4*gi +: 4]} + {1'b0, addend[4*gi +: 4]} + {4'b0000, carry[gi]};
            assign adj = raw + 5'd6;
            assign carry[gi+1] = (raw > 5'd9);
            assign sum_digits[4*gi +: 4] = carry[gi+1] ? adj[3:0] : raw[3:0];
        end
    endgenerate

`ifdef SCORE_SAT_EN
    assign score_next = carry[6] ? 24'h999999 : sum_digits;
`else
    assign score_next = sum_digits;
`endif

    assign lines_sum  = lines_reg + {7'b0000000, nclr_reg};
    assign lines_next = (lines_sum > MAX_LINES) ? MAX_LINES : lines_sum;
    assign sub_sum    = line_sub_reg + {1'b0, nclr_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            base_reg         <= 16'h0000;
            nclr_reg         <= 3'd0;
            reps_reg         <= 5'd0;
            pending_drop_reg <= 1'b0;
            line_sub_reg     <= 4'd0;
            level_reg        <= 4'd0;
            lines_reg        <= 10'd0;
            score_reg        <= 24'h000000;
            level_up_reg     <= 1'b0;
        end else begin
            level_up_reg <= 1'b0;
            // A drop that cannot be scored right now is remembered once; extra pulses are lost.
            if (drop_point && ((state_reg != IDLE) || take))
                pending_drop_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        base_reg  <= base_lut;
                        nclr_reg  <= clear_count;
                        reps_reg  <= {1'b0, level_reg} + 5'd1;
                        state_reg <= ADD;
                    end else if (drop_point || pending_drop_reg) begin
                        score_reg        <= score_next;
                        pending_drop_reg <= 1'b0;
                    end
                end
                ADD: begin
                    score_reg <= score_next;
                    reps_reg  <= reps_reg - 5'd1;
                    if (reps_reg == 5'd1)
                        state_reg <= UPDATE;
                end
                UPDATE: begin
                    lines_reg <= lines_next;
                    if (sub_sum >= LINES_PER_LEVEL) begin
                        line_sub_reg <= sub_sum - LINES_PER_LEVEL;
                        if (level_reg < MAX_LEVEL) begin
                            level_reg    <= level_reg + 4'd1;
                            level_up_reg <= 1'b1;
                        end
                    end else begin
                        line_sub_reg <= sub_sum;
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign clear_ready = (state_reg == IDLE);
    assign busy        = ~clear_ready;
    assign level       = level_reg;
    assign lines       = lines_reg;
    assign score       = score_reg;
    assign level_up    = level_up_reg;

endmodule
